// File: rtl/alu_pkg.sv
// Shared constants for the arbitrated bitwise logic unit: opcodes, FSM
// state encoding and the default datapath width.
package alu_pkg;

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_XNOR = 2'd3;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_logic_unit.sv
// Purely combinational bitwise logic unit (AND/OR/XOR/XNOR), no flags.
module alu_logic_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_op,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    case (i_op)
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      default: o_y = ~(i_a ^ i_b);
    endcase
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one logic unit among NUM_REQ requesters.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
//
// state   | meaning
// ST_IDLE | waiting for a request; grant and capture winner's operands
// ST_EXEC | logic unit evaluates captured operands; result registered
// ST_RESP | result held on rsp_* until rsp_ready
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = ALU_WIDTH,
  parameter int IDW     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]   req_op,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [IDW-1:0]         rsp_id,
  output logic                   busy
);

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [1:0]         r_op;
  logic [IDW-1:0]     r_id;
  logic               r_rsp_valid;
  logic [WIDTH-1:0]   r_rsp_data;
  logic [IDW-1:0]     r_rsp_id;

  logic               w_found;
  logic [IDW-1:0]     w_gnt_id;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic [WIDTH-1:0]   w_sel_a, w_sel_b, w_alu_y;
  logic [1:0]         w_sel_op;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]     r_rr_ptr;
`endif

  // Pass 1 (round-robin only) looks at indices at or above the pointer;
  // pass 2 is plain lowest-index priority, which also covers the wrap.
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_gnt_oh = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[i] && (i >= int'(r_rr_ptr))) begin
        w_found     = 1'b1;
        w_gnt_id    = IDW'(i);
        w_gnt_oh[i] = 1'b1;
        w_sel_a     = req_a[i*WIDTH +: WIDTH];
        w_sel_b     = req_b[i*WIDTH +: WIDTH];
        w_sel_op    = req_op[i*2 +: 2];
      end
    end
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[i]) begin
        w_found     = 1'b1;
        w_gnt_id    = IDW'(i);
        w_gnt_oh[i] = 1'b1;
        w_sel_a     = req_a[i*WIDTH +: WIDTH];
        w_sel_b     = req_b[i*WIDTH +: WIDTH];
        w_sel_op    = req_op[i*2 +: 2];
      end
    end
  end

  alu_logic_unit #(.WIDTH(WIDTH)) u_logic (
    .i_a  (r_a),
    .i_b  (r_b),
    .i_op (r_op),
    .o_y  (w_alu_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        // Gated by rst_n so no requester sees a handshake during reset.
        if (rst_n) req_ready = w_gnt_oh;
        if (w_found) w_state_nxt = ST_EXEC;
      end
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      r_rr_ptr    <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (w_found) begin
          r_a  <= w_sel_a;
          r_b  <= w_sel_b;
          r_op <= w_sel_op;
          r_id <= w_gnt_id;
`ifndef ALU_ARB_FIXED_PRIO_EN
          r_rr_ptr <= (int'(w_gnt_id) == NUM_REQ-1) ? '0 : w_gnt_id + 1'b1;
`endif
        end
        ST_EXEC: begin
          r_rsp_data  <= w_alu_y;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
        end
        ST_RESP: if (rsp_ready) r_rsp_valid <= 1'b0;
        default: r_rsp_valid <= 1'b0;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter; honours ALU_ARB_FIXED_PRIO_EN for
// the grant-order expectations.
module tb_alu_req_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a, req_b;
  logic [7:0]   req_op;
  logic         rsp_valid, rsp_ready;
  logic [31:0]  rsp_data;
  logic [1:0]   rsp_id;
  logic         busy;

  int total = 0;
  int bad   = 0;

  alu_req_arbiter #(.NUM_REQ(4), .WIDTH(32), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic do_op(input vec_t v);
    int n;
    req_valid       = '0;
    req_valid[v.id] = 1'b1;
    req_a[v.id*32 +: 32] = v.a;
    req_b[v.id*32 +: 32] = v.b;
    req_op[v.id*2 +: 2]  = v.op;
    #1;
    n = 0;
    while (!req_ready[v.id] && n < 20) begin
      tick();
      n++;
    end
    chk("op_grant", {28'd0, req_ready}, 32'd1 << v.id);
    tick();
    req_valid = '0;
    chk("op_exec_busy", {31'd0, busy}, 32'd1);
    chk("op_exec_novalid", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("op_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("op_rsp_data", rsp_data, v.exp);
    chk("op_rsp_id", {30'd0, rsp_id}, v.id);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("op_done_valid", {31'd0, rsp_valid}, 32'd0);
    chk("op_done_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int got;
    int ids[8];
    logic [31:0] held_data;
    logic [3:0]  exp_next;

    vecs[0] = '{2, 32'hF0F0_1234, 32'h0FF0_FFFF, 2'b10, 32'hFF00_EDCB};
    vecs[1] = '{0, 32'hAAAA_5555, 32'hFFFF_0000, 2'b00, 32'hAAAA_0000};
    vecs[2] = '{0, 32'hAAAA_5555, 32'hFFFF_0000, 2'b01, 32'hFFFF_5555};
    vecs[3] = '{0, 32'hAAAA_5555, 32'hFFFF_0000, 2'b10, 32'h5555_5555};
    vecs[4] = '{0, 32'hAAAA_5555, 32'hFFFF_0000, 2'b11, 32'hAAAA_AAAA};
    vecs[5] = '{1, 32'h1234_5678, 32'h0F0F_0F0F, 2'b00, 32'h0204_0608};
    vecs[6] = '{3, 32'h0000_0000, 32'h0000_0000, 2'b11, 32'hFFFF_FFFF};

    req_valid = 4'b1111;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rsp_ready = 1'b0;

    // Reset with all requesters asserting valid.
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_first_grant", {28'd0, req_ready}, 32'h1);
    req_valid = '0;
    do_reset();

    foreach (vecs[i]) do_op(vecs[i]);

    // Fairness: everyone valid, consumer always ready.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = i;
      req_b[i*32 +: 32] = 32'd0;
      req_op[i*2 +: 2]  = 2'b01;
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        ids[got] = rsp_id;
        chk("fair_data", rsp_data, {30'd0, rsp_id});
        got++;
      end
    end
    chk("fair_count", got, 8);
    for (int i = 0; i < got; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("fair_id", ids[i], 0);
`else
      chk("fair_id", ids[i], i % 4);
`endif
    end
    req_valid = '0;
    rsp_ready = 1'b0;

    // Backpressure: requester 1 XOR, consumer stalls 5 cycles.
    tick();
    do_reset();
    req_a[32 +: 32] = 32'h1111_0000;
    req_b[32 +: 32] = 32'h0101_FFFF;
    req_op[2 +: 2]  = 2'b10;
    req_valid = 4'b0010;
    #1;
    chk("bp_grant", {28'd0, req_ready}, 32'h2);
    tick();
    req_valid = 4'b1111;
    tick();
    held_data = 32'h1010_FFFF;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_data", rsp_data, held_data);
      chk("bp_id", {30'd0, rsp_id}, 32'd1);
      chk("bp_ready_low", {28'd0, req_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_next = 4'b0001;
`else
    exp_next = 4'b0100;
`endif
    chk("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_next_grant", {28'd0, req_ready}, {28'd0, exp_next});
    req_valid = '0;
    tick();
    tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();

    // Reset while in EXEC after granting requester 2.
    do_reset();
    req_a[64 +: 32] = 32'hDEAD_BEEF;
    req_valid = 4'b0100;
    #1;
    chk("rm_grant", {28'd0, req_ready}, 32'h4);
    tick();
    req_valid = '0;
    chk("rm_in_exec", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rm_no_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rm_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("rm_no_valid2", {31'd0, rsp_valid}, 32'd0);
    req_valid = 4'b1111;
    #1;
    chk("rm_grant0", {28'd0, req_ready}, 32'h1);
    req_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
